// File: rtl/sequencer_pkg.sv
// Shared types for the LUT-programmed command sequencer.
// Holds the state codes, the packed LUT entry layout, width constants
// and the state-to-enable decode used by the FSM output register.
package sequencer_pkg;

  localparam int ENTRY_W = 37;
  localparam int RPT_W   = 8;
  localparam int LEN_W   = 16;
  localparam int STATE_W = 3;
  localparam int NXT_W   = 8;
  localparam int EN_W    = 6;

  typedef enum logic [STATE_W-1:0] {
    RST          = 3'd0,
    IDLE         = 3'd1,
    PANEL_STABLE = 3'd2,
    BACK_BIAS    = 3'd3,
    FLUSH        = 3'd4,
    AED_DETECT   = 3'd5,
    EXPOSE_TIME  = 3'd6,
    READOUT      = 3'd7
  } state_t;

  // Declared MSB first so that next_state lands in bits [2:0].
  typedef struct packed {
    logic [NXT_W-1:0] next_address;
    logic             sof;
    logic             eof;
    logic [LEN_W-1:0] data_length;
    logic [RPT_W-1:0] repeat_count;
    state_t           next_state;
  } lut_entry_t;

  // Enable vector bit order: {readout, expose, aed, flush, bias, panel}.
  function automatic logic [EN_W-1:0] state_enables(input state_t s);
    logic [EN_W-1:0] en;
    en = '0;
    case (s)
      PANEL_STABLE: en[0] = 1'b1;
      BACK_BIAS:    en[1] = 1'b1;
      FLUSH:        en[2] = 1'b1;
      AED_DETECT:   en[3] = 1'b1;
      EXPOSE_TIME:  en[4] = 1'b1;
      READOUT:      en[5] = 1'b1;
      default:      en    = '0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/sequencer_lut_ram.sv
// Sequencer LUT storage: distributed RAM with synchronous write, an
// asynchronous read port for the FSM fetch, and a registered readback port
// with its own post-incrementing pointer.
// Optional: SEQ_LUT_READBACK_EN builds the readback path; otherwise the
// readback data is constant 0.
module sequencer_lut_ram
  import sequencer_pkg::*;
#(
  parameter int LUT_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [ENTRY_W-1:0] rd_data,
  input  logic               rb_en,
  output logic [ENTRY_W-1:0] rb_data
);

  logic [ENTRY_W-1:0] mem [LUT_DEPTH];

  // Contents are never reset so a reset mid-sequence keeps the program.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

`ifdef SEQ_LUT_READBACK_EN
  logic [ADDR_W-1:0]  rb_ptr_reg;
  logic [ENTRY_W-1:0] rb_data_reg;

  // Host readback: one word per strobe, pointer advances after each read.
  always_ff @(posedge clk) begin
    if (srst) begin
      rb_ptr_reg  <= '0;
      rb_data_reg <= '0;
    end else if (rb_en) begin
      rb_data_reg <= mem[rb_ptr_reg];
      rb_ptr_reg  <= rb_ptr_reg + 1'b1;
    end
  end

  assign rb_data = rb_data_reg;
`else
  logic unused_rb;
  assign unused_rb = rb_en | srst;
  assign rb_data   = '0;
`endif

endmodule

// File: rtl/sequencer_fsm.sv
// LUT-driven command sequencer. The host loads the LUT while the FSM sits
// in RST; afterwards the FSM walks linked entries, dwelling
// (repeat_count+1)*max(data_length,1) cycles on each and driving the
// one-hot command enables. All outputs are registered.
// Optional: SEQ_LUT_READBACK_EN enables registered LUT readback.
module sequencer_fsm
  import sequencer_pkg::*;
#(
  parameter int LUT_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               lut_wen_i,
  input  logic [ENTRY_W-1:0] lut_write_data_i,
  input  logic               lut_rden_i,
  input  logic               config_done_i,
  input  logic               exit_signal_i,
  output logic [ENTRY_W-1:0] lut_read_data_o,
  output logic [STATE_W-1:0] current_state_o,
  output logic               busy_o,
  output logic               sequence_done_o,
  output logic               panel_enable_o,
  output logic               bias_enable_o,
  output logic               flush_enable_o,
  output logic               aed_enable_o,
  output logic               expose_enable_o,
  output logic               readout_enable_o,
  output logic [RPT_W-1:0]   current_repeat_count_o,
  output logic [LEN_W-1:0]   current_data_length_o,
  output logic               current_eof_o,
  output logic               current_sof_o
);

  // active_reg separates "IDLE waiting to fetch" from a timed IDLE entry.
  state_t             state_reg, state_next;
  logic               active_reg, active_next;
  logic [ADDR_W-1:0]  lut_addr_reg, lut_addr_next;
  logic [ADDR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0]  next_addr_reg, next_addr_next;
  logic [LEN_W-1:0]   tmr_reg, tmr_next;
  logic [RPT_W-1:0]   rpt_reg, rpt_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic               eof_reg, eof_next;
  logic               sof_reg, sof_next;
  logic [EN_W-1:0]    en_reg, en_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

  logic               wr_en;
  logic               load_entry;
  logic [ADDR_W-1:0]  fetch_addr;
  logic [ENTRY_W-1:0] fetch_data;
  lut_entry_t         fetch_entry;
  logic [LEN_W-1:0]   len_eff;
  logic               pass_end;

  sequencer_lut_ram #(
    .LUT_DEPTH (LUT_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_lut (
    .clk     (clk),
    .srst    (reset_i),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg),
    .wr_data (lut_write_data_i),
    .rd_addr (fetch_addr),
    .rd_data (fetch_data),
    .rb_en   (lut_rden_i),
    .rb_data (lut_read_data_o)
  );

  // While an entry runs we prefetch its successor so it loads with no bubble.
  assign fetch_addr  = active_reg ? next_addr_reg : lut_addr_reg;
  assign fetch_entry = lut_entry_t'(fetch_data);
  assign len_eff     = (len_reg == '0) ? LEN_W'(1) : len_reg;
  assign pass_end    = (tmr_reg == len_eff - LEN_W'(1));

  // Next-state, dwell timing and registered-output computation.
  always_comb begin
    state_next     = state_reg;
    active_next    = active_reg;
    lut_addr_next  = lut_addr_reg;
    wr_ptr_next    = wr_ptr_reg;
    next_addr_next = next_addr_reg;
    tmr_next       = tmr_reg;
    rpt_next       = rpt_reg;
    len_next       = len_reg;
    eof_next       = eof_reg;
    sof_next       = sof_reg;
    done_next      = 1'b0;
    wr_en          = 1'b0;
    load_entry     = 1'b0;

    case (state_reg)
      RST: begin
        wr_en         = lut_wen_i & ~reset_i;
        lut_addr_next = '0;
        active_next   = 1'b0;
        if (lut_wen_i) begin
          wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (config_done_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        if (!active_reg) begin
          load_entry = config_done_i;
        end else if (!pass_end) begin
          tmr_next = tmr_reg + 1'b1;
        end else if (rpt_reg != '0) begin
          rpt_next = rpt_reg - 1'b1;
          tmr_next = '0;
        end else begin
          lut_addr_next = next_addr_reg;
          if (eof_reg && exit_signal_i) begin
            // Sequence ends; current_* read 0 until the next fetch.
            done_next   = 1'b1;
            state_next  = IDLE;
            active_next = 1'b0;
            rpt_next    = '0;
            len_next    = '0;
            eof_next    = 1'b0;
            sof_next    = 1'b0;
            tmr_next    = '0;
          end else begin
            load_entry = 1'b1;
          end
        end
      end
    endcase

    if (load_entry) begin
      if (fetch_entry.next_state == RST) begin
        // Unprogrammed (all-zero) entry: fall back to RST.
        state_next    = RST;
        active_next   = 1'b0;
        lut_addr_next = '0;
        rpt_next      = '0;
        len_next      = '0;
        eof_next      = 1'b0;
        sof_next      = 1'b0;
        tmr_next      = '0;
      end else begin
        state_next     = fetch_entry.next_state;
        active_next    = 1'b1;
        next_addr_next = fetch_entry.next_address;
        rpt_next       = fetch_entry.repeat_count;
        len_next       = fetch_entry.data_length;
        eof_next       = fetch_entry.eof;
        sof_next       = fetch_entry.sof;
        tmr_next       = '0;
      end
    end

    en_next   = state_enables(state_next);
    busy_next = !(state_next inside {RST, IDLE});
  end

  // State and registered outputs; reset aborts everything but RAM contents.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_reg     <= RST;
      active_reg    <= 1'b0;
      lut_addr_reg  <= '0;
      wr_ptr_reg    <= '0;
      next_addr_reg <= '0;
      tmr_reg       <= '0;
      rpt_reg       <= '0;
      len_reg       <= '0;
      eof_reg       <= 1'b0;
      sof_reg       <= 1'b0;
      en_reg        <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      active_reg    <= active_next;
      lut_addr_reg  <= lut_addr_next;
      wr_ptr_reg    <= wr_ptr_next;
      next_addr_reg <= next_addr_next;
      tmr_reg       <= tmr_next;
      rpt_reg       <= rpt_next;
      len_reg       <= len_next;
      eof_reg       <= eof_next;
      sof_reg       <= sof_next;
      en_reg        <= en_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  assign current_state_o        = state_reg;
  assign busy_o                 = busy_reg;
  assign sequence_done_o        = done_reg;
  assign panel_enable_o         = en_reg[0];
  assign bias_enable_o          = en_reg[1];
  assign flush_enable_o         = en_reg[2];
  assign aed_enable_o           = en_reg[3];
  assign expose_enable_o        = en_reg[4];
  assign readout_enable_o       = en_reg[5];
  assign current_repeat_count_o = rpt_reg;
  assign current_data_length_o  = len_reg;
  assign current_eof_o          = eof_reg;
  assign current_sof_o          = sof_reg;

endmodule

// File: tb/tb_sequencer_fsm.sv
// Bench for sequencer_fsm: directed phases with randomized entry fields and
// exit timing, checked every cycle against a behavioural model that tracks
// elapsed cycles per entry and derives outputs arithmetically.
module tb_sequencer_fsm;

  logic        clk;
  logic        reset_i;
  logic        lut_wen_i;
  logic [36:0] lut_write_data_i;
  logic        lut_rden_i;
  logic        config_done_i;
  logic        exit_signal_i;
  logic [36:0] lut_read_data_o;
  logic [2:0]  current_state_o;
  logic        busy_o;
  logic        sequence_done_o;
  logic        panel_enable_o, bias_enable_o, flush_enable_o;
  logic        aed_enable_o, expose_enable_o, readout_enable_o;
  logic [7:0]  current_repeat_count_o;
  logic [15:0] current_data_length_o;
  logic        current_eof_o;
  logic        current_sof_o;

  sequencer_fsm dut (
    .clk                    (clk),
    .reset_i                (reset_i),
    .lut_wen_i              (lut_wen_i),
    .lut_write_data_i       (lut_write_data_i),
    .lut_rden_i             (lut_rden_i),
    .config_done_i          (config_done_i),
    .exit_signal_i          (exit_signal_i),
    .lut_read_data_o        (lut_read_data_o),
    .current_state_o        (current_state_o),
    .busy_o                 (busy_o),
    .sequence_done_o        (sequence_done_o),
    .panel_enable_o         (panel_enable_o),
    .bias_enable_o          (bias_enable_o),
    .flush_enable_o         (flush_enable_o),
    .aed_enable_o           (aed_enable_o),
    .expose_enable_o        (expose_enable_o),
    .readout_enable_o       (readout_enable_o),
    .current_repeat_count_o (current_repeat_count_o),
    .current_data_length_o  (current_data_length_o),
    .current_eof_o          (current_eof_o),
    .current_sof_o          (current_sof_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode 0 = RST, 1 = IDLE awaiting fetch, 2 = entry running.
  logic [36:0] m_lut [256];
  logic [36:0] m_ent;
  logic [36:0] m_rdata;
  logic [7:0]  m_addr, m_wr, m_rd;
  int          m_mode;
  int          m_elapsed;
  bit          m_done;

  logic [36:0] prog [15];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [36:0] mk(input int ns, input int rpt, input int len,
                                     input int eof, input int sof, input int nxt);
    logic [36:0] w;
    w[2:0]   = ns[2:0];
    w[10:3]  = rpt[7:0];
    w[26:11] = len[15:0];
    w[27]    = eof[0];
    w[28]    = sof[0];
    w[36:29] = nxt[7:0];
    return w;
  endfunction

  function automatic int ent_len_eff(input logic [36:0] e);
    return (e[26:11] == 16'd0) ? 1 : int'(e[26:11]);
  endfunction

  task automatic m_load(input logic [7:0] a);
    m_ent = m_lut[a];
    if (m_ent[2:0] == 3'd0) begin
      m_mode = 0;
      m_ent  = '0;
      m_addr = '0;
    end else begin
      m_mode    = 2;
      m_elapsed = 0;
    end
  endtask

  task automatic model_step();
    int total;
    m_done = 1'b0;
    if (reset_i) begin
      m_mode  = 0;
      m_wr    = '0;
      m_rd    = '0;
      m_addr  = '0;
      m_rdata = '0;
      m_ent   = '0;
    end else begin
`ifdef SEQ_LUT_READBACK_EN
      if (lut_rden_i) begin
        m_rdata = m_lut[m_rd];
        m_rd    = m_rd + 8'd1;
      end
`endif
      case (m_mode)
        0: begin
          if (lut_wen_i) begin
            m_lut[m_wr] = lut_write_data_i;
            m_wr        = m_wr + 8'd1;
          end
          if (config_done_i) begin
            m_mode = 1;
            m_addr = '0;
          end
        end
        1: if (config_done_i) m_load(m_addr);
        default: begin
          total = (int'(m_ent[10:3]) + 1) * ent_len_eff(m_ent);
          if (m_elapsed == total - 1) begin
            m_addr = m_ent[36:29];
            if (m_ent[27] && exit_signal_i) begin
              m_done = 1'b1;
              m_mode = 1;
              m_ent  = '0;
            end else begin
              m_load(m_ent[36:29]);
            end
          end else begin
            m_elapsed++;
          end
        end
      endcase
    end
  endtask

  task automatic check_outputs();
    int         st;
    logic [5:0] one;
    logic [5:0] en_exp;
    logic [5:0] en_obs;
    one = 6'd1;
    st  = (m_mode == 2) ? int'(m_ent[2:0]) : m_mode;
    en_exp = (st >= 2) ? (one << (st - 2)) : 6'd0;
    en_obs = {readout_enable_o, expose_enable_o, aed_enable_o,
              flush_enable_o, bias_enable_o, panel_enable_o};
    chk("state", 64'(current_state_o), 64'(st));
    chk("enables", 64'(en_obs), 64'(en_exp));
    chk("busy", 64'(busy_o), 64'(st >= 2));
    chk("done", 64'(sequence_done_o), 64'(m_done));
    chk("readback", 64'(lut_read_data_o), 64'(m_rdata));
    if (m_mode == 2) begin
      chk("repeat", 64'(current_repeat_count_o),
          64'(int'(m_ent[10:3]) - m_elapsed / ent_len_eff(m_ent)));
      chk("length", 64'(current_data_length_o), 64'(m_ent[26:11]));
      chk("eof_sof", 64'({current_eof_o, current_sof_o}), 64'({m_ent[27], m_ent[28]}));
    end else begin
      chk("fields_zero", 64'({current_repeat_count_o, current_data_length_o,
                              current_eof_o, current_sof_o}), 64'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  int  dut_done;
  bit  seen;
  int  delay;

  initial begin
    for (int i = 0; i < 256; i++) m_lut[i] = '0;
    m_ent = '0; m_rdata = '0; m_addr = '0; m_wr = '0; m_rd = '0;
    m_mode = 0; m_elapsed = 0; m_done = 1'b0;

    prog[0] = mk(2, 0, 5, 0, 1, 1);
    prog[1] = mk(3, 3, 10, 0, 0, 2);
    prog[2] = mk(4, 1, 3, 0, 0, 3);
    prog[3] = mk(6, int'($urandom_range(0, 2)), 0, 0, 0, 4);
    prog[4] = mk(5, int'($urandom_range(0, 2)), int'($urandom_range(1, 4)), 0, 0, 5);
    prog[5] = mk(6, 0, int'($urandom_range(0, 6)), 0, 0, 6);
    prog[6] = mk(7, 0, 40, 1, 0, 7);
    prog[7] = mk(1, 1, 1, 0, 0, 5);
    for (int i = 8; i < 15; i++) begin
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      prog[i] = r[36:0];
    end

    reset_i = 1'b1; config_done_i = 1'b0; exit_signal_i = 1'b0;
    lut_wen_i = 1'b0; lut_rden_i = 1'b0; lut_write_data_i = '0;

    // Reset state, then leave RST to IDLE and reset again.
    tick(); tick();
    reset_i = 1'b0; config_done_i = 1'b1;
    tick();
    reset_i = 1'b1; config_done_i = 1'b0;
    tick();
    reset_i = 1'b0;

    // Program 15 entries back-to-back, then read them back.
    for (int i = 0; i < 15; i++) begin
      lut_wen_i = 1'b1; lut_write_data_i = prog[i];
      tick();
    end
    lut_wen_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      lut_rden_i = 1'b1;
      tick();
    end
    lut_rden_i = 1'b0;
    tick();

    // Run the sequence with exit low: looping, never done.
    config_done_i = 1'b1;
    dut_done = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (sequence_done_o) dut_done++;
    end
    chk("no_done_exit_low", 64'(dut_done), 64'd0);

    // Raise exit at a random point; expect exactly one done pulse.
    delay = int'($urandom_range(0, 45));
    for (int i = 0; i < delay; i++) tick();
    exit_signal_i = 1'b1;
    dut_done = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (sequence_done_o) dut_done++;
      if (m_done) seen = 1'b1;
    end
    chk("exit_reached", 64'(seen), 64'd1);
    exit_signal_i = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (sequence_done_o) dut_done++;
    end
    chk("done_once", 64'(dut_done), 64'd1);

    // Restart from address 0 and abort with reset during FLUSH.
    reset_i = 1'b1; config_done_i = 1'b0;
    tick();
    reset_i = 1'b0; config_done_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (m_mode == 2 && m_ent[2:0] == 3'd4) seen = 1'b1;
    end
    chk("flush_reached", 64'(seen), 64'd1);
    delay = int'($urandom_range(0, 4));
    for (int i = 0; i < delay; i++) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    for (int i = 0; i < 80; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sequencer_fsm.md
Name: sequencer_fsm

Overview:
- LUT-programmed command sequencer for the detector-panel control path.
- Host loads a 256-entry x 37-bit LUT RAM while the FSM is held in RST.
- Once configured, the FSM walks linked LUT entries. Each entry selects a command state, a dwell length and a repeat count, and drives one-hot command enables to the panel, bias, flush, AED, expose and readout blocks.

Parameters:
- LUT_DEPTH, 256, number of LUT entries; equals 2**ADDR_W.
- ADDR_W, 8, LUT address / next_address width.

Ports:
- clk  in  1  single clock domain; all logic on rising edge.
- reset_i  in  1  reset, synchronous, active-high.
- lut_wen_i  in  1  LUT write strobe; accepted only in RST.
- lut_write_data_i  in  37  packed entry written at the auto-incrementing write pointer.
- lut_rden_i  in  1  LUT readback strobe.
- config_done_i  in  1  1 = LUT programmed; allows leaving RST.
- exit_signal_i  in  1  request to end the sequence at the next EOF entry.
- lut_read_data_o  out  37  registered readback data.
- current_state_o  out  3  FSM state code.
- busy_o  out  1  1 in any command state (2..7).
- sequence_done_o  out  1  one-cycle done pulse.
- panel_enable_o, bias_enable_o, flush_enable_o, aed_enable_o, expose_enable_o, readout_enable_o  out  1 each  command enables.
- current_repeat_count_o  out  8  remaining repeats of the active entry.
- current_data_length_o  out  16  dwell length of the active entry.
- current_eof_o  out  1  EOF flag of the active entry.
- current_sof_o  out  1  SOF flag of the active entry.

Behaviour:
- Entry format, fields listed LSB first:
  - [2:0] next_state
  - [10:3] repeat_count
  - [26:11] data_length
  - [27] eof
  - [28] sof
  - [36:29] next_address
- State codes: RST=0, IDLE=1, PANEL_STABLE=2, BACK_BIAS=3, FLUSH=4, AED_DETECT=5, EXPOSE_TIME=6, READOUT=7.
- Reset (reset_i=1 at an edge):
  - State goes to RST.
  - Write pointer, read pointer and lut_addr_reg go to 0; timers are cleared.
  - All outputs go to 0, including lut_read_data_o.
  - RAM contents are preserved.
  - Reset mid-sequence aborts immediately with the same values.
- RST:
  - lut_wen_i=1 writes lut_write_data_i to RAM[wr_ptr]; wr_ptr increments and wraps 255->0.
  - Leaves to IDLE at the first edge where reset_i=0 and config_done_i=1.
  - lut_wen_i outside RST is ignored.
- Readback: lut_rden_i=1 registers RAM[rd_ptr] onto lut_read_data_o, 1-cycle latency; rd_ptr post-increments. This works in any state.
- IDLE with config_done_i=1:
  - Fetch entry at lut_addr_reg. RAM read is asynchronous.
  - Next edge loads the active-entry registers: state<=next_state, rpt<=repeat_count, tmr<=0.
- Command dwell:
  - Each pass lasts max(data_length,1) cycles.
  - repeat_count=N gives N+1 passes; rpt decrements at each pass end.
  - Total dwell = (N+1)*max(len,1) cycles.
- Entry end (final cycle of the final pass):
  - If eof=1 and exit_signal_i=1 on that cycle: sequence_done_o pulses for 1 cycle, state<=IDLE, lut_addr_reg<=next_address.
  - Otherwise: lut_addr_reg<=next_address and the entry at next_address loads on the same edge with no bubble.
  - An entry whose next_state=IDLE is a timed wait in IDLE (busy_o=0), then continues to its next_address.
- exit_signal_i is level-sensitive and ignored on non-EOF entries.
- Outputs are registered and track the active entry:
  - Exactly one enable is high per command state 2..7; all enables are 0 in RST and IDLE.
  - current_* show the active entry; in RST they are 0.
- Unprogrammed entries read as 0 (next_state=RST). Reaching such an entry sends the FSM to RST.

Optional Feature:
- SEQ_LUT_READBACK_EN
- Defined: rd_ptr and the lut_read_data_o register are present as described.
- Undefined: lut_rden_i is ignored and lut_read_data_o is tied to 0, saving readback logic.

Decomposition:
- Package sequencer_pkg holds:
  - state_t enum with the 8 codes
  - lut_entry_t packed struct in the field order above
  - width constants: 37, 8, 16, 3
  - function mapping a state to its enable vector
- One sub-module, sequencer_lut_ram: 256x37 distributed RAM with sync write, async read port for the FSM, and registered readback port.

Test Plan:
- Reset, then reset_i=0 with config_done_i=1 -> current_state_o=1 (IDLE) one edge later; all enables, busy_o and sequence_done_o = 0.
- Hold RST with config_done_i=0 and write 15 entries back-to-back; then lut_rden_i x15 -> lut_read_data_o matches each written word 1 cycle after its strobe; wr_ptr ends at 15.
- Entry0 = {PANEL_STABLE, rpt 0, len 5, next 1}, entry1 = {BACK_BIAS, rpt 3, len 10, next 2} -> panel_enable_o high 5 cycles, then bias_enable_o high 40 cycles with current_repeat_count_o counting 3,2,1,0.
- Loop 5->6(EOF)->7(IDLE, rpt 1, len 1)->5 with exit_signal_i=0 -> repeats indefinitely, sequence_done_o never asserts, busy_o=0 for 2 cycles per loop.
- Raise exit_signal_i mid-loop -> sequence_done_o pulses exactly once on the edge ending the READOUT EOF entry (len 40); state goes to IDLE; lut_addr_reg=7.
- Assert reset_i during FLUSH -> RST next edge, all outputs 0; after config_done_i, execution restarts from address 0 with LUT contents intact.
